// File: rtl/nes_pkg.sv
// Shared types for the NES bus controller: host opcodes, controller states
// and the default CPU reset-hold length.
package nes_pkg;

  localparam int unsigned RESET_CYCLES_DEF = 8;

  typedef enum logic [7:0] {
    OP_RESET_CPU = 8'd0,
    OP_START_CPU = 8'd1,
    OP_PAUSE_CPU = 8'd2,
    OP_WRITE_MEM = 8'd3,
    OP_READ_MEM  = 8'd4,
    OP_STEP_CPU  = 8'd5
  } nes_op_t;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_PAUSED,
    ST_RUN,
    ST_HWR,
    ST_HRD,
    ST_RESTORE,
    ST_STEP
  } ctrl_state_t;

endpackage

// File: rtl/nes_bus_ctrl.sv
// Sequences the 6502 core and shares the single-port NES memory between the
// core and the host slave port.
//   host side : chipselect, write, writedata[15:8]=opcode/[7:0]=data, address,
//               waitrequest, readdata (last READ_MEM result)
//   cpu side  : cpu_reset, cpu_ready, cpu_addr, cpu_write, cpu_dout, cpu_din
//   memory    : mem_addr, mem_write, mem_in, mem_out (read valid next cycle)
//   status    : running, cycle_count (cycles with cpu_ready high)
module nes_bus_ctrl
  import nes_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic [15:0]       writedata,
  input  logic [ADDR_W-1:0] address,
  output logic              waitrequest,
  output logic [7:0]        readdata,
  output logic              cpu_reset,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [7:0]        mem_in,
  input  logic [7:0]        mem_out,
  output logic              running,
  output logic [31:0]       cycle_count
);

  localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  ctrl_state_t       state, state_next;
  logic [CNT_W-1:0]  rst_cnt;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_data;
  logic              host_rd;
  logic              ret_run;
  logic [7:0]        op;
  logic              accept;

  assign op      = writedata[15:8];
  assign accept  = chipselect & write & ~waitrequest;
  assign cpu_din = mem_out;

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:   if (rst_cnt == RST_LAST) state_next = ST_PAUSED;
      ST_PAUSED: begin
        if (accept) begin
          case (op)
            OP_START_CPU: state_next = ST_RUN;
            OP_STEP_CPU:  state_next = ST_STEP;
            OP_RESET_CPU: state_next = ST_RESET;
            OP_WRITE_MEM: state_next = ST_HWR;
            OP_READ_MEM:  state_next = ST_HRD;
            default:      state_next = state;
          endcase
        end
      end
      ST_RUN: begin
        if (accept) begin
          case (op)
            OP_PAUSE_CPU: state_next = ST_PAUSED;
            OP_RESET_CPU: state_next = ST_RESET;
            OP_WRITE_MEM: state_next = ST_HWR;
            OP_READ_MEM:  state_next = ST_HRD;
            default:      state_next = state;
          endcase
        end
      end
      ST_HWR, ST_HRD: state_next = ST_RESTORE;
      ST_RESTORE:     state_next = ret_run ? ST_RUN : ST_PAUSED;
      ST_STEP:        state_next = ST_PAUSED;
      default:        state_next = ST_RESET;
    endcase
  end

  always_comb begin
    cpu_reset   = 1'b0;
    cpu_ready   = 1'b0;
    waitrequest = 1'b1;
    running     = 1'b0;
    mem_addr    = cpu_addr;
    mem_write   = 1'b0;
    mem_in      = '0;
    case (state)
      ST_RESET: begin
        cpu_reset = 1'b1;
        mem_addr  = '0;
      end
      ST_PAUSED: waitrequest = 1'b0;
      ST_RUN: begin
        waitrequest = 1'b0;
        cpu_ready   = 1'b1;
        running     = 1'b1;
        mem_in      = cpu_dout;
        mem_write   = cpu_write;
      end
      ST_STEP: begin
        cpu_ready = 1'b1;
        mem_in    = cpu_dout;
        mem_write = cpu_write;
      end
      ST_HWR: begin
        mem_addr  = host_addr;
        mem_in    = host_data;
        mem_write = 1'b1;
      end
      ST_HRD:     mem_addr = host_addr;
      ST_RESTORE: mem_addr = cpu_addr;
      default: begin
        cpu_reset = 1'b1;
        mem_addr  = '0;
      end
    endcase
    // Reset overrides combinationally so a pending HWR cannot write on the
    // same edge that aborts it.
    if (reset) begin
      cpu_reset   = 1'b1;
      cpu_ready   = 1'b0;
      waitrequest = 1'b1;
      running     = 1'b0;
      mem_addr    = '0;
      mem_write   = 1'b0;
      mem_in      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RESET;
      rst_cnt     <= '0;
      cycle_count <= '0;
      readdata    <= '0;
      host_addr   <= '0;
      host_data   <= '0;
      host_rd     <= 1'b0;
      ret_run     <= 1'b0;
    end else begin
      state <= state_next;

      if (state == ST_RESET && state_next == ST_RESET) rst_cnt <= rst_cnt + 1'b1;
      else                                             rst_cnt <= '0;

      if (accept && op == OP_RESET_CPU) cycle_count <= '0;
      else if (cpu_ready)               cycle_count <= cycle_count + 32'd1;

      if (accept && (op == OP_WRITE_MEM || op == OP_READ_MEM)) begin
        host_addr <= address;
        host_data <= writedata[7:0];
        host_rd   <= (op == OP_READ_MEM);
        ret_run   <= (state == ST_RUN);
      end

      if (state == ST_RESTORE && host_rd) readdata <= mem_out;
    end
  end

endmodule
